regs_file_mp: RTL

Parametrised multi-port integer register file that succeeds the single-write, dual-read register file. It adds N read ports, M write ports with fixed priority, optional write-to-read bypass, a hardwired zero register, asynchronous reset of the array, and a per-register busy scoreboard. The scoreboard lets the issue stage detect RAW hazards against in-flight writebacks. It sits between decode/issue and the writeback stage of the pipeline.

---
 rtl/regs_file_mp.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/regs_file_mp.sv
// regs_file_mp: multi-port integer register file with a per-register busy scoreboard.
// Latency: reads and busy flags are combinational; writes, reserves and flushes land on the next posedge.
// Backpressure: none. Every write, reserve and flush strobe is accepted in the cycle it is presented.
//
// Ports:
//   clk, rstN        : rising-edge clock, asynchronous active-low reset (clears array and scoreboard)
//   regsNum          : READ_PORTS packed read indices, port k at [k*ADDR_W +: ADDR_W]
//   regsReadData     : READ_PORTS packed read data, port k at [k*XLEN +: XLEN]
//   regsReadBusy     : per read port, register has a pending writeback
//   regsWriteEnable  : per write port strobe; regsWriteNum / regsWriteData packed like the reads
//   reserveEnable    : mark reserveNum busy (issued instruction with a destination)
//   flush            : clear every busy bit
module regs_file_mp #(
  parameter int XLEN        = 32,
  parameter int REG_COUNT   = 32,
  parameter int ADDR_W      = 5,
  parameter int READ_PORTS  = 2,
  parameter int WRITE_PORTS = 2,
  parameter int BYPASS      = 1,
  parameter int ZERO_REG    = 1
) (
  input  logic                         clk,
  input  logic                         rstN,
  input  logic [READ_PORTS*ADDR_W-1:0] regsNum,
  output logic [READ_PORTS*XLEN-1:0]   regsReadData,
  output logic [READ_PORTS-1:0]        regsReadBusy,
  input  logic [WRITE_PORTS-1:0]       regsWriteEnable,
  input  logic [WRITE_PORTS*ADDR_W-1:0] regsWriteNum,
  input  logic [WRITE_PORTS*XLEN-1:0]  regsWriteData,
  input  logic                         reserveEnable,
  input  logic [ADDR_W-1:0]            reserveNum,
  input  logic                         flush
);

  // Elaboration-time parameter sanity.
  if (REG_COUNT < 2 || REG_COUNT > 64 || (1 << ADDR_W) != REG_COUNT ||
      ADDR_W != $clog2(REG_COUNT)) begin : g_bad_addr
    $error("regs_file_mp: ADDR_W must equal log2(REG_COUNT), REG_COUNT a power of two in 2..64");
  end
  if (READ_PORTS < 1 || READ_PORTS > 4) begin : g_bad_rd
    $error("regs_file_mp: READ_PORTS must be in 1..4");
  end
  if (WRITE_PORTS < 1 || WRITE_PORTS > 3) begin : g_bad_wr
    $error("regs_file_mp: WRITE_PORTS must be in 1..3");
  end

  logic [XLEN-1:0]      regs_q [REG_COUNT];
  logic [REG_COUNT-1:0] busy_q;

  // Per-register write decode. Ports are scanned in ascending order so the
  // highest-index matching port leaves the final value. Register 0 is masked
  // here when hardwired, which also keeps its busy bit permanently clear.
  logic [REG_COUNT-1:0] wr_hit;
  logic [XLEN-1:0]      wr_val [REG_COUNT];
  logic [REG_COUNT-1:0] res_hit;

  always_comb begin
    for (int r = 0; r < REG_COUNT; r++) begin
      wr_hit[r]  = 1'b0;
      wr_val[r]  = '0;
      res_hit[r] = 1'b0;
      if (ZERO_REG == 0 || r != 0) begin
        for (int j = 0; j < WRITE_PORTS; j++) begin
          if (regsWriteEnable[j] && regsWriteNum[j*ADDR_W +: ADDR_W] == ADDR_W'(r)) begin
            wr_hit[r] = 1'b1;
            wr_val[r] = regsWriteData[j*XLEN +: XLEN];
          end
        end
        res_hit[r] = reserveEnable && (reserveNum == ADDR_W'(r));
      end
    end
  end

  // Register array.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      for (int r = 0; r < REG_COUNT; r++) begin
        regs_q[r] <= '0;
      end
    end else begin
      for (int r = 0; r < REG_COUNT; r++) begin
        if (wr_hit[r]) begin
          regs_q[r] <= wr_val[r];
        end
      end
    end
  end

  // Busy scoreboard: flush beats reserve, reserve beats a same-cycle
  // writeback because the newly issued producer supersedes the old one.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      busy_q <= '0;
    end else if (flush) begin
      busy_q <= '0;
    end else begin
      for (int r = 0; r < REG_COUNT; r++) begin
        if (res_hit[r]) begin
          busy_q[r] <= 1'b1;
        end else if (wr_hit[r]) begin
          busy_q[r] <= 1'b0;
        end
      end
    end
  end

  // Read ports.
  for (genvar k = 0; k < READ_PORTS; k++) begin : g_rd
    logic [ADDR_W-1:0] idx;
    logic [XLEN-1:0]   data;
    logic              busy;

    assign idx = regsNum[k*ADDR_W +: ADDR_W];

    always_comb begin
      data = regs_q[idx];
      busy = busy_q[idx];
      if (BYPASS != 0) begin
        // Forwarded data is valid now, so the pending writeback no longer
        // counts as a hazard for this reader.
        for (int j = 0; j < WRITE_PORTS; j++) begin
          if (regsWriteEnable[j] && regsWriteNum[j*ADDR_W +: ADDR_W] == idx) begin
            data = regsWriteData[j*XLEN +: XLEN];
            busy = 1'b0;
          end
        end
      end
      if (ZERO_REG != 0 && idx == '0) begin
        data = '0;
        busy = 1'b0;
      end
      // During reset the outputs reflect the cleared state, not the bypass.
      if (!rstN) begin
        data = '0;
        busy = 1'b0;
      end
    end

    assign regsReadData[k*XLEN +: XLEN] = data;
    assign regsReadBusy[k]              = busy;
  end

endmodule
